// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller stage-status and pipeline-control bundle
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       fd_rs_addr_i;
    logic [4:0]       fd_rd_addr_i;
    logic             fd_uses_rs_i;
    logic             fd_uses_rd_i;
    logic             dx_is_load_i;
    logic [4:0]       dx_wb_addr_i;
    logic             x_branch_taken_i;
    logic             mem_busy_i;
    logic             pc_stall_o;
    logic             fd_stall_o;
    logic             fd_flush_o;
    logic             dx_stall_o;
    logic             dx_flush_o;
    logic             dx_bubble_o;
    logic             xm_stall_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_events_o;

    modport slave (
        input  fd_rs_addr_i, fd_rd_addr_i, fd_uses_rs_i, fd_uses_rd_i,
        input  dx_is_load_i, dx_wb_addr_i, x_branch_taken_i, mem_busy_i,
        output pc_stall_o, fd_stall_o, fd_flush_o, dx_stall_o, dx_flush_o,
        output dx_bubble_o, xm_stall_o, stall_cycles_o, flush_events_o
    );

    modport master (
        output fd_rs_addr_i, fd_rd_addr_i, fd_uses_rs_i, fd_uses_rd_i,
        output dx_is_load_i, dx_wb_addr_i, x_branch_taken_i, mem_busy_i,
        input  pc_stall_o, fd_stall_o, fd_flush_o, dx_stall_o, dx_flush_o,
        input  dx_bubble_o, xm_stall_o, stall_cycles_o, flush_events_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush/bubble controller with perf counters
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             resume_q, resume_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             flush_inc;
    logic             load_use;

    logic pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, dx_bubble, xm_stall;

    // A load in DX whose result the FD instruction needs; r0 never carries a dependency.
    always_comb begin
        load_use = bus.dx_is_load_i && (bus.dx_wb_addr_i != 5'd0) &&
                   ((bus.fd_uses_rs_i && (bus.fd_rs_addr_i == bus.dx_wb_addr_i)) ||
                    (bus.fd_uses_rd_i && (bus.fd_rd_addr_i == bus.dx_wb_addr_i)));
    end

    // Prioritised control outputs and next-state: reset > busy > branch > drain > load-use.
    always_comb begin
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        fd_flush  = 1'b0;
        dx_stall  = 1'b0;
        dx_flush  = 1'b0;
        dx_bubble = 1'b0;
        xm_stall  = 1'b0;
        flush_inc = 1'b0;
        state_d   = state_q;
        drain_d   = drain_q;
        resume_d  = resume_q;

        if (!rst_n) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            state_d  = RUN;
            drain_d  = 4'd0;
            resume_d = 1'b0;
        end else if (bus.mem_busy_i) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            dx_stall = 1'b1;
            xm_stall = 1'b1;
            state_d  = MEM_WAIT;
            // Remember an interrupted drain; drain_cnt stays frozen while held.
            if (state_q == REDIRECT) begin
                resume_d = 1'b1;
            end
        end else begin
            // Release from MEM_WAIT behaves as RUN this cycle; an interrupted drain resumes next.
            if (state_q == MEM_WAIT) begin
                resume_d = 1'b0;
                state_d  = (resume_q && (drain_q != 4'd0)) ? REDIRECT : RUN;
            end
            if (bus.x_branch_taken_i) begin
                fd_flush  = 1'b1;
                dx_flush  = 1'b1;
                flush_inc = 1'b1;
                resume_d  = 1'b0;
                if (FLUSH_CYCLES > 1) begin
                    drain_d = DRAIN_INIT;
                    state_d = REDIRECT;
                end else begin
                    drain_d = 4'd0;
                    state_d = RUN;
                end
            end else if (state_q == REDIRECT) begin
                fd_flush = 1'b1;
                drain_d  = drain_q - 4'd1;
                state_d  = (drain_q == 4'd1) ? RUN : REDIRECT;
            end else if (load_use) begin
                pc_stall  = 1'b1;
                fd_stall  = 1'b1;
                dx_bubble = 1'b1;
            end
        end
    end

    // State, drain counter and resume flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            drain_q  <= 4'd0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            resume_q <= resume_d;
        end
    end

    // Saturating performance counters for stalled cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_stall_o     = pc_stall;
    assign bus.fd_stall_o     = fd_stall;
    assign bus.fd_flush_o     = fd_flush;
    assign bus.dx_stall_o     = dx_stall;
    assign bus.dx_flush_o     = dx_flush;
    assign bus.dx_bubble_o    = dx_bubble;
    assign bus.xm_stall_o     = xm_stall;
    assign bus.stall_cycles_o = stall_cnt_q;
    assign bus.flush_events_o = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [4:0] rs = 5'd0, rd = 5'd0, wb = 5'd0;
    logic       urs = 1'b0, urd = 1'b0, ld = 1'b0, br = 1'b0, busy = 1'b0;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.fd_rs_addr_i = rs;    assign bus_b.fd_rs_addr_i = rs;
    assign bus_a.fd_rd_addr_i = rd;    assign bus_b.fd_rd_addr_i = rd;
    assign bus_a.fd_uses_rs_i = urs;   assign bus_b.fd_uses_rs_i = urs;
    assign bus_a.fd_uses_rd_i = urd;   assign bus_b.fd_uses_rd_i = urd;
    assign bus_a.dx_is_load_i = ld;    assign bus_b.dx_is_load_i = ld;
    assign bus_a.dx_wb_addr_i = wb;    assign bus_b.dx_wb_addr_i = wb;
    assign bus_a.x_branch_taken_i = br; assign bus_b.x_branch_taken_i = br;
    assign bus_a.mem_busy_i = busy;    assign bus_b.mem_busy_i = busy;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Output vector order: {pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, dx_bubble, xm_stall}
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_RESET  = 7'b0010100;
    localparam logic [6:0] O_BUSY   = 7'b1101001;
    localparam logic [6:0] O_BRANCH = 7'b0010100;
    localparam logic [6:0] O_DRAIN  = 7'b0010000;
    localparam logic [6:0] O_LU     = 7'b1100010;

    wire [6:0] obs_a = {bus_a.pc_stall_o, bus_a.fd_stall_o, bus_a.fd_flush_o, bus_a.dx_stall_o,
                        bus_a.dx_flush_o, bus_a.dx_bubble_o, bus_a.xm_stall_o};
    wire [6:0] obs_b = {bus_b.pc_stall_o, bus_b.fd_stall_o, bus_b.fd_flush_o, bus_b.dx_stall_o,
                        bus_b.dx_flush_o, bus_b.dx_bubble_o, bus_b.xm_stall_o};

    int checks = 0;
    int passed = 0;

    // Reference model: owed flush cycles after a branch, interrupted-drain flag, held-by-busy flag.
    int         fc  [2] = '{2, 1};
    int         cap [2] = '{65535, 15};
    int         m_left [2] = '{0, 0};
    bit         m_pend [2] = '{0, 0};
    bit         m_held [2] = '{0, 0};
    int         m_stall[2] = '{0, 0};
    int         m_flush[2] = '{0, 0};
    logic [6:0] exp_o  [2];
    int         exp_sc [2];
    int         exp_fe [2];

    task automatic drive(input logic r, input logic bz, input logic b, input logic l,
                         input logic [4:0] w, input logic [4:0] s, input logic [4:0] d,
                         input logic us, input logic ud);
        bit lu, redir;
        @(posedge clk);
        #1;
        rst_n = r; busy = bz; br = b; ld = l; wb = w; rs = s; rd = d; urs = us; urd = ud;
        lu = l && (w != 0) && ((us && s == w) || (ud && d == w));
        for (int k = 0; k < 2; k++) begin
            exp_sc[k] = m_stall[k];
            exp_fe[k] = m_flush[k];
            if (!r) begin
                exp_o[k] = O_RESET;
                m_left[k] = 0; m_pend[k] = 0; m_held[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else if (bz) begin
                exp_o[k] = O_BUSY;
                if (m_left[k] > 0 && !m_held[k]) m_pend[k] = 1;
                m_held[k] = 1;
                if (m_stall[k] < cap[k]) m_stall[k]++;
            end else begin
                redir = !m_held[k] && (m_left[k] > 0);
                if (m_held[k]) begin
                    if (!m_pend[k]) m_left[k] = 0;
                    m_held[k] = 0;
                    m_pend[k] = 0;
                end
                if (b) begin
                    exp_o[k] = O_BRANCH;
                    m_left[k] = fc[k] - 1;
                    m_pend[k] = 0;
                    if (m_flush[k] < cap[k]) m_flush[k]++;
                end else if (redir) begin
                    exp_o[k] = O_DRAIN;
                    m_left[k]--;
                end else if (lu) begin
                    exp_o[k] = O_LU;
                    if (m_stall[k] < cap[k]) m_stall[k]++;
                end else begin
                    exp_o[k] = O_IDLE;
                end
            end
        end
        #3;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_a !== O_RESET) $display("FAIL reset_outputs got %b want %b", obs_a, O_RESET);
        else passed++;
        idle();
        checks++;
        if (bus_a.stall_cycles_o !== 16'd0 || bus_a.flush_events_o !== 16'd0 || obs_a !== O_IDLE)
            $display("FAIL reset_state got cnt %0d/%0d out %b want 0/0 %b",
                     bus_a.stall_cycles_o, bus_a.flush_events_o, obs_a, O_IDLE);
        else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd9, 1, 0);
        checks++;
        if (obs_a !== O_LU) $display("FAIL load_use_rs got %b want %b", obs_a, O_LU);
        else passed++;
        idle();
        checks++;
        if (obs_a !== O_IDLE || bus_a.stall_cycles_o !== 16'd1)
            $display("FAIL load_use_after got %b cnt %0d want %b cnt 1", obs_a, bus_a.stall_cycles_o, O_IDLE);
        else passed++;
        drive(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
        checks++;
        if (obs_a !== O_LU) $display("FAIL load_use_rd got %b want %b", obs_a, O_LU);
        else passed++;
        drive(1, 0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0);
        checks++;
        if (obs_a !== O_IDLE) $display("FAIL load_use_unused got %b want %b", obs_a, O_IDLE);
        else passed++;
        drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        checks++;
        if (obs_a !== O_IDLE) $display("FAIL load_r0 got %b want %b", obs_a, O_IDLE);
        else passed++;
    endtask

    task automatic test_mem_busy();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
            checks++;
            if (obs_a !== O_BUSY) $display("FAIL busy_cycle%0d got %b want %b", i, obs_a, O_BUSY);
            else passed++;
        end
        drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        checks++;
        if (obs_a !== O_LU) $display("FAIL busy_release got %b want %b", obs_a, O_LU);
        else passed++;
        idle();
        checks++;
        if (bus_a.stall_cycles_o !== 16'd4) $display("FAIL busy_count got %0d want 4", bus_a.stall_cycles_o);
        else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_a !== O_BRANCH || obs_b !== O_BRANCH)
            $display("FAIL branch_cycle got %b/%b want %b", obs_a, obs_b, O_BRANCH);
        else passed++;
        drive(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        checks++;
        if (obs_a !== O_DRAIN || obs_b !== O_LU)
            $display("FAIL branch_drain got %b/%b want %b/%b", obs_a, obs_b, O_DRAIN, O_LU);
        else passed++;
        drive(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        checks++;
        if (obs_a !== O_LU || bus_a.flush_events_o !== 16'd1)
            $display("FAIL branch_done got %b ev %0d want %b ev 1", obs_a, bus_a.flush_events_o, O_LU);
        else passed++;
    endtask

    task automatic test_branch_busy();
        logic [6:0] seq [6];
        seq = '{O_BRANCH, O_BUSY, O_BUSY, O_IDLE, O_DRAIN, O_IDLE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, (i == 1 || i == 2), (i == 0), 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs_a !== seq[i]) $display("FAIL branch_busy_step%0d got %b want %b", i, obs_a, seq[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        do_reset();
        checks++;
        if (obs_a !== O_RESET) $display("FAIL reset_mid got %b want %b", obs_a, O_RESET);
        else passed++;
        idle();
        checks++;
        if (obs_a !== O_IDLE || bus_a.flush_events_o !== 16'd0)
            $display("FAIL reset_mid_after got %b ev %0d want %b ev 0", obs_a, bus_a.flush_events_o, O_IDLE);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        checks++;
        if (bus_b.stall_cycles_o !== 4'd15 || bus_a.stall_cycles_o !== 16'd20)
            $display("FAIL saturate got %0d/%0d want 15/20", bus_b.stall_cycles_o, bus_a.stall_cycles_o);
        else passed++;
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        checks++;
        if (bus_b.flush_events_o !== 4'd15 || bus_a.flush_events_o !== 16'd20)
            $display("FAIL saturate_flush got %0d/%0d want 15/20", bus_b.flush_events_o, bus_a.flush_events_o);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                  $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
            if (obs_a !== exp_o[0] || obs_b !== exp_o[1] ||
                bus_a.stall_cycles_o !== 16'(exp_sc[0]) || bus_a.flush_events_o !== 16'(exp_fe[0]) ||
                bus_b.stall_cycles_o !== 4'(exp_sc[1]) || bus_b.flush_events_o !== 4'(exp_fe[1]) ||
                (bus_a.fd_stall_o && bus_a.fd_flush_o) || (bus_a.dx_stall_o && bus_a.dx_flush_o)) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d got %b/%b cnt %0d,%0d,%0d,%0d want %b/%b cnt %0d,%0d,%0d,%0d",
                             i, obs_a, obs_b, bus_a.stall_cycles_o, bus_a.flush_events_o,
                             bus_b.stall_cycles_o, bus_b.flush_events_o, exp_o[0], exp_o[1],
                             exp_sc[0], exp_fe[0], exp_sc[1] & 15, exp_fe[1] & 15);
                errs++;
            end
        end
        checks++;
        if (errs != 0) $display("FAIL random_total got %0d bad cycles want 0", errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_busy();
        test_branch();
        test_branch_busy();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the 5-stage pipeline: generates the per-stage `stall`, `flush` and `bubble` controls consumed by the FD, DX and XM pipeline registers and the PC. It resolves load-use hazards, data-memory wait states and taken-branch redirects with a fixed priority. It sequences multi-cycle redirect drains through a small FSM and keeps saturating stall/flush event counters for performance debug. It sits beside the datapath, between the decode/execute/memory stage outputs and the pipeline register control pins.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `fd_flush_o` stays asserted per taken branch (fetch redirect latency); legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: single clock, all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `fd_rs_addr_i` in 5: rs field of the instruction in FD.
- `fd_rd_addr_i` in 5: rd field of the instruction in FD.
- `fd_uses_rs_i` in 1: FD instruction reads rs.
- `fd_uses_rd_i` in 1: FD instruction reads rd as a source.
- `dx_is_load_i` in 1: DX instruction is a load.
- `dx_wb_addr_i` in 5: destination register of the DX instruction.
- `x_branch_taken_i` in 1: branch resolved taken in X this cycle.
- `mem_busy_i` in 1: data memory not ready; M stage must hold.
- `pc_stall_o` out 1: hold PC.
- `fd_stall_o` out 1: hold FD register.
- `fd_flush_o` out 1: load NOP into FD register.
- `dx_stall_o` out 1: hold DX register.
- `dx_flush_o` out 1: load NOP into DX register.
- `dx_bubble_o` out 1: insert NOP into DX register (load-use).
- `xm_stall_o` out 1: hold XM register.
- `stall_cycles_o` out `CNT_W`: saturating count of cycles with `pc_stall_o`=1.
- `flush_events_o` out `CNT_W`: saturating count of accepted taken branches.

## Operation
- FSM states: RUN, MEM_WAIT, REDIRECT. Registers: state, 4-bit `drain_cnt`, `resume_redirect` flag, two counters.
- Output priority, highest first: reset > mem_busy > branch > redirect drain > load-use.
- Reset (`rst_n`=0): outputs `fd_flush_o`=`dx_flush_o`=1, all others 0. Next state RUN, `drain_cnt`=0, `resume_redirect`=0, counters 0.
- `mem_busy_i`=1, any state:
  - `pc_stall_o`, `fd_stall_o`, `dx_stall_o` and `xm_stall_o`=1; all flush/bubble outputs 0.
  - Next state MEM_WAIT. If entered from REDIRECT, set `resume_redirect` and freeze `drain_cnt`.
- MEM_WAIT with `mem_busy_i`=0:
  - Evaluate exactly as RUN this cycle.
  - Next state RUN, or REDIRECT if `resume_redirect`=1 and `drain_cnt`>0. Clear `resume_redirect`.
- `x_branch_taken_i`=1 without busy, in RUN/MEM_WAIT/REDIRECT:
  - `fd_flush_o`=`dx_flush_o`=1, no stalls, load-use suppressed.
  - `flush_events_o`++.
  - If `FLUSH_CYCLES`>1: `drain_cnt`=`FLUSH_CYCLES`-1, next REDIRECT. Else next RUN.
  - A branch seen in REDIRECT restarts the drain.
- REDIRECT without busy or branch:
  - `fd_flush_o`=1, all others 0, load-use suppressed.
  - Decrement `drain_cnt`; go to RUN when it reaches 0.
- Load-use hazard: asserted when `dx_is_load_i` and `dx_wb_addr_i`≠0, and either `fd_uses_rs_i` with `fd_rs_addr_i`==`dx_wb_addr_i` or `fd_uses_rd_i` with `fd_rd_addr_i`==`dx_wb_addr_i`.
  - Response: `pc_stall_o`=`fd_stall_o`=`dx_bubble_o`=1.
  - Naturally one cycle: the load advances to XM.
- `stall_cycles_o` increments each cycle `pc_stall_o`=1. Both counters saturate at all-ones.
- Stall and flush never both asserted on the same register output.

## Timing
- All control outputs are combinational (Mealy) from inputs and current state; zero-cycle latency to pipeline-register pins.
- State, `drain_cnt` and counters are registered; counter values visible the cycle after the event.
- Branch in cycle T with `FLUSH_CYCLES`=N: `fd_flush_o` high T..T+N-1 (minus any busy cycles, which extend the window); `dx_flush_o` only at T.
- Reset mid-REDIRECT or mid-MEM_WAIT aborts the sequence; the next cycle is RUN with counters 0.

## Test plan
- Load-use: DX load to r5, FD reads rs=r5 → one cycle `pc_stall_o`=`fd_stall_o`=`dx_bubble_o`=1, then 0; `stall_cycles_o`=1.
- r0 destination: DX load to r0, FD reads r0 → no bubble, no stall.
- `mem_busy_i` high 3 cycles, with a simultaneous load-use hazard → all four stalls for 3 cycles, `dx_bubble_o`=0; bubble fires on the release cycle; `stall_cycles_o`=4.
- Branch, `FLUSH_CYCLES`=2 → `fd_flush_o` 2 cycles, `dx_flush_o` 1 cycle, `flush_events_o`=1; a load-use hazard during the drain is ignored.
- Branch, then `mem_busy_i` 2 cycles during the drain → stalls only for 2 cycles, then the remaining `fd_flush_o` cycle, then RUN.
- `rst_n` low mid-REDIRECT → both flushes high during reset; counters 0; RUN afterwards. Force the counter to all-ones (`CNT_W`=4, 20 stalls) → holds at 15.
